// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and the iteration-counter width helper.
package multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_CALC_ENC = 2'b01;
    localparam logic [1:0] ST_DONE_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_CALC = ST_CALC_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Counter must be able to hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplier_if.sv
// Start/Done/Ack handshake bundle for the multiplier. The master launches
// an operation with operands and acknowledges the product; the slave is
// the multiplier itself.
interface multiplier_if #(
    parameter int WIDTH = multiplier_pkg::DEFAULT_WIDTH
);
    logic                   start;
    logic                   ack;
    logic [WIDTH-1:0]       mult_q;
    logic [WIDTH-1:0]       mult_r;
    logic                   done;
    logic [2*WIDTH-1:0]     mult_p;

    modport master (
        output start, ack, mult_q, mult_r,
        input  done, mult_p
    );

    modport slave (
        input  start, ack, mult_q, mult_r,
        output done, mult_p
    );
endinterface

// File: rtl/multiplier_datapath.sv
// Multiplier datapath: shifted multiplicand A, shifting multiplier B,
// running product P and iteration counter. Load initialises an operation,
// step performs one shift-and-add iteration. P is a plain register and is
// driven straight to the product output.
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(DEFAULT_WIDTH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [WIDTH-1:0]    i_q,
    input  logic [WIDTH-1:0]    i_r,
    output logic [2*WIDTH-1:0]  o_p,
    output logic [CW-1:0]       o_count,
    output logic                o_b_next_zero
);

    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_count;

    // Load operands on launch, otherwise add-if-bit-set and shift once per step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= {(2*WIDTH){1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_p     <= {(2*WIDTH){1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_load) begin
            r_a     <= {{WIDTH{1'b0}}, i_q};
            r_b     <= i_r;
            r_p     <= {(2*WIDTH){1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_step) begin
            if (r_b[0]) begin
                r_p <= r_p + r_a;
            end else begin
                r_p <= r_p;
            end
            r_a     <= r_a << 1;
            r_b     <= r_b >> 1;
            r_count <= r_count + CW'(1);
        end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_p     <= r_p;
            r_count <= r_count;
        end
    end

    assign o_p           = r_p;
    assign o_count       = r_count;
    // No further multiplier bits remain once the current one is consumed.
    assign o_b_next_zero = ((r_b >> 1) == {WIDTH{1'b0}});

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// with a Start/Done/Ack handshake. Control FSM lives here; the arithmetic
// is in multiplier_datapath.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always iterating WIDTH times.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    multiplier_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

`ifdef MULT_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    state_t              r_state;
    logic                r_done;
    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic                w_b_next_zero;
    logic [CW-1:0]       w_count;
    logic [2*WIDTH-1:0]  w_p;

    // Start only matters in IDLE; iterations only happen in CALC.
    assign w_load = (r_state == ST_IDLE) && bus.start;
    assign w_step = (r_state == ST_CALC);
    // Current CALC edge is the final one (count still holds the pre-increment value).
    assign w_last = (w_count == CW'(WIDTH - 1)) || (EARLY_EXIT && w_b_next_zero);

    multiplier_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_q           (bus.mult_q),
        .i_r           (bus.mult_r),
        .o_p           (w_p),
        .o_count       (w_count),
        .o_b_next_zero (w_b_next_zero)
    );

    // Control FSM with registered Done: IDLE -> CALC -> DONE -> IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_CALC;
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done   = r_done;
    assign bus.mult_p = w_p;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed handshake corner cases,
// exhaustive 4x4 products and randomized operations with random ack delay,
// all compared against a plain arithmetic reference.
module tb_multiplier;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    multiplier_if #(.WIDTH(W)) bus ();

    multiplier #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference latency: WIDTH edges, or (early-exit build) top set bit of R + 1.
    function automatic int ref_latency(input logic [W-1:0] r);
        int hb;
`ifdef MULT_EARLY_EXIT_EN
        hb = 0;
        for (int i = 0; i < W; i++) begin
            if (r[i]) hb = i;
        end
        return hb + 1;
`else
        hb = W;
        return hb;
`endif
    endfunction

    // Count edges after the launch edge until Done is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Launch at the next negedge; returns just after the launch edge.
    task automatic launch(input logic [W-1:0] q, input logic [W-1:0] r);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mult_q = q;
        bus.mult_r = r;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // One full transaction; ack_wait==0 means Ack is held high throughout.
    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] r, input int ack_wait);
        int cyc;
        int exp_p;
        exp_p = int'(q) * int'(r);
        bus.ack = (ack_wait == 0);
        launch(q, r);
        wait_done(cyc);
        check_eq("latency", cyc, ref_latency(r));
        check_eq("product", {16'd0, bus.mult_p}, exp_p);
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk);
            #1;
            check_eq("done_hold", {31'd0, bus.done}, 32'd1);
        end
        if (ack_wait > 0) begin
            @(negedge clk);
            bus.ack = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("done_drop", {31'd0, bus.done}, 32'd0);
        check_eq("product_after_ack", {16'd0, bus.mult_p}, exp_p);
        if (ack_wait > 0) begin
            @(negedge clk);
            bus.ack = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus.mult_q = 4'd0;
        bus.mult_r = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_done", {31'd0, bus.done}, 32'd0);
        check_eq("reset_p", {16'd0, bus.mult_p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a calculation.
        launch(4'd9, 4'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midcalc_rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("midcalc_rst_p", {16'd0, bus.mult_p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_after_rst", {31'd0, bus.done}, 32'd0);
        run_op(4'd9, 4'd7, 0);

        // Largest operands.
        run_op(4'd15, 4'd15, 0);

        // Ack withheld for 10 cycles.
        run_op(4'd6, 4'd7, 10);

        // Start and operand changes during CALC are ignored.
        bus.ack = 1'b1;
        launch(4'd3, 4'd5);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mult_q = 4'd15;
        bus.mult_r = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        #4;
        wait_done(cyc);
        check_eq("norestart_latency", cyc + 1, ref_latency(4'd5));
        check_eq("norestart_p", {16'd0, bus.mult_p}, 32'd15);
        @(posedge clk);
        #1;

        // Start together with Ack in DONE: Ack wins, Start launches from IDLE.
        bus.ack = 1'b0;
        launch(4'd2, 4'd3);
        wait_done(cyc);
        check_eq("both_first_p", {16'd0, bus.mult_p}, 32'd6);
        @(negedge clk);
        bus.ack    = 1'b1;
        bus.start  = 1'b1;
        bus.mult_q = 4'd5;
        bus.mult_r = 4'd7;
        @(posedge clk);
        #1;
        check_eq("both_done_drop", {31'd0, bus.done}, 32'd0);
        check_eq("both_p_held", {16'd0, bus.mult_p}, 32'd6);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        check_eq("both_second_latency", cyc, ref_latency(4'd7));
        check_eq("both_second_p", {16'd0, bus.mult_p}, 32'd35);
        @(posedge clk);
        #1;
        bus.ack = 1'b0;

        // Exhaustive operand sweep with Ack held high.
        for (int q = 0; q < 16; q++) begin
            for (int r = 0; r < 16; r++) begin
                run_op(4'(q), 4'(r), 0);
            end
        end

        // Randomized operands and acknowledge delays.
        for (int n = 0; n < 60; n++) begin
            run_op(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                   int'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned shift-and-add multiplier: WIDTH-bit Multiplier_Q × WIDTH-bit Multiplier_R → 2·WIDTH-bit Multiplier_P.
- Start/Done/Ack handshake; one product per transaction.
- Leaf arithmetic block driven by a controller (or a bench) that launches an operation and acknowledges the result.

Parameters:
- WIDTH, 4, operand width; product width is 2*WIDTH.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  launch request; sampled only in IDLE.
- Ack  in  1  result acknowledge; sampled only in DONE.
- Multiplier_Q  in  WIDTH  multiplicand; sampled on the Start edge only.
- Multiplier_R  in  WIDTH  multiplier; sampled on the Start edge only.
- Done  out  1  registered; high while in DONE.
- Multiplier_P  out  2*WIDTH  registered product.

Behaviour:
- Reset low (asynchronous): state=IDLE, Done=0, Multiplier_P=0, internal A/B/count=0. This applies at any time, including mid-computation; an aborted operation is lost.
- States: IDLE, CALC, DONE. Encoding is a localparam in the package.
- IDLE:
  - On edge with Start=1: A←zero-extended Multiplier_Q (2*WIDTH bits), B←Multiplier_R, P←0, count←0, go to CALC.
  - Start=0: remain in IDLE, P holds the previous result.
- CALC, each edge:
  - if B[0], P←P+A (2*WIDTH-bit add, no overflow possible).
  - A←A<<1, B←B>>1, count←count+1.
  - After the WIDTH-th CALC edge, go to DONE.
  - Start and operand changes are ignored during CALC.
- Latency: Start sampled at edge k → Done=1 and final P valid after edge k+WIDTH (k+4 for default).
- DONE:
  - Done=1, P stable.
  - On edge with Ack=1: go to IDLE, Done←0, P holds the result.
  - Ack=0: hold DONE indefinitely.
- Ack held high continuously: Done is a one-cycle pulse.
- Start and Ack both high in DONE: Ack is honoured, Start ignored. Start must be seen in IDLE (one cycle later at earliest) to launch.
- Ack in IDLE/CALC: ignored.
- Back-to-back operations: minimum period WIDTH+2 cycles (Start, WIDTH calc, DONE/ack).
- Zero operands: no special case in base build; full WIDTH cycles, P=0.

Optional Feature:
- MULT_EARLY_EXIT_EN defined: in CALC, when the next B value (B>>1) is zero, go directly to DONE after the current edge.
  - R=0 or R=1 → Done after 1 CALC cycle.
  - Latency = index of the highest set bit of R + 1 (minimum 1).
- Not defined: fixed WIDTH-cycle latency as above.
- The product value is identical in both builds.

Decomposition:
- Package multiplier_pkg: state enum/localparams (ST_IDLE, ST_CALC, ST_DONE), default WIDTH constant, count width function ($clog2(WIDTH+1)).
- Optional sub-module multiplier_datapath: holds the A/B/P registers and the adder, with load/step controls. The FSM stays in the top module.

Test Plan:
- Reset low mid-CALC (Q=9, R=7) → Done=0, P=0 immediately (asynchronous). After release, IDLE; next Start computes normally.
- Q=15, R=15, Start pulse, Ack=1 → Done high exactly WIDTH cycles after the Start edge, P=8'hE1 (225). Done drops the next cycle.
- Exhaustive Q,R in 0..15 with Ack=1 → P=Q*R for all 256 pairs (e.g. 0×5=0, 1×15=15, 12×10=120, 8×8=64).
- Ack=0 held for 10 cycles after completion (Q=6, R=7) → Done stays 1, P=42 stable. Ack pulse → Done=0, P still 42.
- Operands changed and Start re-pulsed during CALC (Q=3, R=5, then Q=15, R=15) → P=15, no restart.
- MULT_EARLY_EXIT_EN build: R=1, Q=13 → Done after 1 CALC cycle, P=13. R=8, Q=3 → Done after 4 cycles, P=24.
